// File: rtl/ysyx_25060170_pkg.sv
// Shared decode constants and FSM state type for the EXU and its mul/div engine.
package ysyx_25060170_pkg;

    // Major opcodes
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // funct3 for the integer ALU
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 for the M extension
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // funct7 selecting the M extension within OP
    localparam logic [6:0] F7_M = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_25060170_mdu.sv
// Iterative RV32M engine: one shift-add or restoring-division step per cycle
// on operand magnitudes, with the sign fix-up applied on the final step.
// done pulses on the cycle of the last step; result is valid alongside it.
module ysyx_25060170_mdu
    import ysyx_25060170_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]     cnt;
    logic              busy;
    logic [2*XLEN-1:0] acc;       // {hi/remainder, lo/multiplier-quotient}
    logic [XLEN-1:0]   opb;       // multiplicand or divisor magnitude
    logic [2:0]        op_q;
    logic              neg_main;  // negate product or quotient
    logic              neg_rem;   // negate remainder

    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic              q_bit;
    logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;
    logic [XLEN-1:0]   quot, rem;

    // Operand signedness and magnitudes captured at start
    always_comb begin
        a_sgn = (op == F3_MUL) || (op == F3_MULH) || (op == F3_MULHSU) ||
                (op == F3_DIV) || (op == F3_REM);
        b_sgn = (op == F3_MUL) || (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
        a_neg = a_sgn && a[XLEN-1];
        b_neg = b_sgn && b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One iteration step and the sign-corrected result of the step
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, opb};
        q_bit    = !diff[XLEN];
        div_next = {(q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], q_bit};
        acc_next = op_q[2] ? div_next : mul_next;
        prod     = neg_main ? -acc_next : acc_next;
        quot     = neg_main ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem      = neg_rem ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        case (op_q)
            F3_MUL:                        result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  result = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               result = quot;
            default:                       result = rem;
        endcase
        done = busy && (cnt == CW'(1));
    end

    // Iteration state: load on start, step while busy, stop after XLEN steps
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            op_q     <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= CW'(XLEN);
            acc      <= {{XLEN{1'b0}}, a_mag};
            opb      <= b_mag;
            op_q     <= op;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
        end else if (busy) begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_25060170_exu_md.sv
// Execution unit: single-cycle ALU/decode, iterative M extension through the
// mdu, and a registered result held until the writeback stage takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready. On the
// input side in_ready is high in IDLE, or in DONE when the held result is
// leaving in the same cycle; on the output side out_valid is high exactly in
// DONE and result/rd/trap stay stable until out_ready.
module ysyx_25060170_exu_md
    import ysyx_25060170_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RV_M = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [4:0]      rd_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            trap_o,
    output state_e          dbg_state
);

    localparam int SHW = $clog2(XLEN);

    state_e          state, state_n;
    logic            accept, load_fast, load_mdu, mdu_start, mdu_done;
    logic            m_iter, fast_trap, div0, ovf;
    logic [XLEN-1:0] op_b, fast_result, mdu_result;
    logic [SHW-1:0]  shamt;

    assign accept    = in_valid && in_ready;
    assign in_ready  = rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    // Decode: ALU result, trap, and whether an M op needs the iterative engine
    always_comb begin
        op_b        = (opcode_i == OP) ? rs2_data_i : imm_i;
        shamt       = op_b[SHW-1:0];
        div0        = (rs2_data_i == '0);
        ovf         = (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
        fast_result = '0;
        fast_trap   = 1'b0;
        m_iter      = 1'b0;
        if ((opcode_i == OP) && (funct7_i == F7_M)) begin
            if (RV_M != 0) begin
                case (funct3_i)
                    F3_DIV:  if (div0) fast_result = '1;
                             else if (ovf) fast_result = rs1_data_i;
                             else m_iter = 1'b1;
                    F3_DIVU: if (div0) fast_result = '1; else m_iter = 1'b1;
                    F3_REM:  if (div0) fast_result = rs1_data_i;
                             else if (!ovf) m_iter = 1'b1;
                    F3_REMU: if (div0) fast_result = rs1_data_i; else m_iter = 1'b1;
                    default: m_iter = 1'b1;
                endcase
            end
        end else begin
            case (opcode_i)
                OP, OP_IMM: begin
                    case (funct3_i)
                        F3_ADD:  fast_result = ((opcode_i == OP) && funct7_i[5]) ?
                                               rs1_data_i - op_b : rs1_data_i + op_b;
                        F3_SLL:  fast_result = rs1_data_i << shamt;
                        F3_SLT:  fast_result = {{(XLEN-1){1'b0}},
                                                ($signed(rs1_data_i) < $signed(op_b))};
                        F3_SLTU: fast_result = {{(XLEN-1){1'b0}}, (rs1_data_i < op_b)};
                        F3_XOR:  fast_result = rs1_data_i ^ op_b;
                        F3_SR:   fast_result = funct7_i[5] ?
                                               XLEN'($signed(rs1_data_i) >>> shamt) :
                                               rs1_data_i >> shamt;
                        F3_OR:   fast_result = rs1_data_i | op_b;
                        default: fast_result = rs1_data_i & op_b;
                    endcase
                end
                LUI:          fast_result = imm_i;
                AUIPC:        fast_result = pc_i + imm_i;
                JAL, JALR:    fast_result = pc_i + XLEN'(4);
                LOAD, STORE:  fast_result = rs1_data_i + imm_i;
                SYSTEM:       fast_trap   = (imm_i == XLEN'(1));
                default:      fast_result = '0;
            endcase
        end
    end

    // Handshake FSM: next state and register load strobes
    always_comb begin
        state_n   = state;
        load_fast = 1'b0;
        load_mdu  = 1'b0;
        mdu_start = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (m_iter) begin
                        mdu_start = 1'b1;
                        state_n   = BUSY;
                    end else begin
                        load_fast = 1'b1;
                        state_n   = DONE;
                    end
                end else if ((state == DONE) && out_ready) begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                if (mdu_done) begin
                    load_mdu = 1'b1;
                    state_n  = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Output register: loaded on fast accept or on the final mdu step
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_o <= '0;
            rd_o     <= '0;
            trap_o   <= 1'b0;
        end else if (load_fast) begin
            result_o <= fast_result;
            rd_o     <= rd_i;
            trap_o   <= fast_trap;
        end else if (mdu_start) begin
            rd_o     <= rd_i;
            trap_o   <= 1'b0;
        end else if (load_mdu) begin
            result_o <= mdu_result;
        end
    end

    ysyx_25060170_mdu #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .op     (funct3_i),
        .a      (rs1_data_i),
        .b      (rs2_data_i),
        .done   (mdu_done),
        .result (mdu_result)
    );

endmodule

// File: tb/tb_ysyx_25060170_exu_md.sv
// Directed bench for the EXU: expected responses are queued on issue and a
// negedge monitor pops and compares each result the DUT hands to writeback.
module tb_ysyx_25060170_exu_md;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pc_i = '0, rs1_data_i = '0, rs2_data_i = '0, imm_i = '0;
    logic [6:0]  opcode_i = '0, funct7_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [4:0]  rd_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        trap_o;
    logic [1:0]  dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [37:0] exp_q[$];   // {trap, rd, result}

    ysyx_25060170_exu_md dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_i(rd_i),
        .out_valid(out_valid), .out_ready(out_ready), .result_o(result_o),
        .rd_o(rd_o), .trap_o(trap_o), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: every output transfer consumes one expected entry
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_output", {63'd0, out_valid}, 64'd0);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                check("sb_trap_rd_result", {26'd0, trap_o, rd_o, result_o}, {26'd0, e});
            end
        end
    end

    // Present one instruction and hold it until accepted
    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] p, input logic [4:0] rd, output int waited);
        opcode_i = opc; funct3_i = f3; funct7_i = f7;
        rs1_data_i = a; rs2_data_i = b; imm_i = im; pc_i = p; rd_i = rd;
        in_valid = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 60);
        if (!in_ready) check("accept_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count cycles from acceptance until out_valid, and in_ready-low cycles
    task automatic wait_out(input string name, input int exp_lat, input int exp_busy);
        int n = 0;
        int low = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && !in_ready) low++;
        end while (!out_valid && n < 100);
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(low), 64'(exp_busy));
        check({name, "_in_ready_with_valid"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run(input string name, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p, input logic [4:0] rd,
                       input logic [31:0] exp_res, input logic exp_trap, input int lat);
        int waited;
        exp_q.push_back({exp_trap, rd, exp_res});
        drive(opc, f3, f7, a, b, im, p, rd, waited);
        check({name, "_accept_wait"}, 64'(waited), 64'd1);
        wait_out(name, lat, (lat > 1) ? lat - 1 : 0);
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] C_OP = 7'b0110011, C_OPI = 7'b0010011, C_LUI = 7'b0110111;
    localparam logic [6:0] C_AUIPC = 7'b0010111, C_JAL = 7'b1101111, C_LOAD = 7'b0000011;
    localparam logic [6:0] C_SYS = 7'b1110011, F7M = 7'b0000001, F7A = 7'b0100000;

    initial begin
        int waited;
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd0);
        check("reset_result", {32'd0, result_o}, 64'd0);
        check("reset_rd_trap", {58'd0, rd_o, trap_o}, 64'd0);
        check("reset_state", {62'd0, dbg_state}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single-cycle ALU and address paths
        run("addi",   C_OPI, 3'd0, 7'd0, 32'd5, 32'd0, 32'hFFFFFFFD, 32'd0, 5'd3, 32'd2, 1'b0, 1);
        run("sra",    C_OP, 3'd5, F7A, 32'h80000000, 32'd4, 32'd0, 32'd0, 5'd6, 32'hF8000000, 1'b0, 1);
        run("srl",    C_OP, 3'd5, 7'd0, 32'h80000000, 32'd4, 32'd0, 32'd0, 5'd7, 32'h08000000, 1'b0, 1);
        run("slt",    C_OP, 3'd2, 7'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd8, 32'd1, 1'b0, 1);
        run("sltu",   C_OP, 3'd3, 7'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd9, 32'd0, 1'b0, 1);
        run("slli33", C_OPI, 3'd1, 7'd0, 32'd3, 32'd0, 32'd33, 32'd0, 5'd10, 32'd6, 1'b0, 1);
        run("xori",   C_OPI, 3'd4, 7'd0, 32'h0F0F0F0F, 32'd0, 32'hFFFFFFFF, 32'd0, 5'd11, 32'hF0F0F0F0, 1'b0, 1);
        run("auipc",  C_AUIPC, 3'd0, 7'd0, 32'd0, 32'd0, 32'h00001000, 32'h80000000, 5'd12, 32'h80001000, 1'b0, 1);
        run("jal",    C_JAL, 3'd0, 7'd0, 32'd0, 32'd0, 32'd8, 32'h00000100, 5'd1, 32'h00000104, 1'b0, 1);
        run("lw",     C_LOAD, 3'd2, 7'd0, 32'h00001000, 32'd0, 32'hFFFFFFFC, 32'd0, 5'd13, 32'h00000FFC, 1'b0, 1);

        // Iterative M extension
        run("mul",    C_OP, 3'd0, F7M, 32'd7, 32'hFFFFFFFD, 32'd0, 32'd0, 5'd4, 32'hFFFFFFEB, 1'b0, 33);
        run("mulhu",  C_OP, 3'd3, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd14, 32'hFFFFFFFE, 1'b0, 33);
        run("mulh",   C_OP, 3'd1, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd15, 32'd0, 1'b0, 33);
        run("mulhsu", C_OP, 3'd2, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd16, 32'hFFFFFFFF, 1'b0, 33);
        run("div",    C_OP, 3'd4, F7M, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 5'd17, 32'hFFFFFFFD, 1'b0, 33);
        run("rem",    C_OP, 3'd6, F7M, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 5'd18, 32'hFFFFFFFF, 1'b0, 33);
        run("remu",   C_OP, 3'd7, F7M, 32'd100, 32'd7, 32'd0, 32'd0, 5'd19, 32'd2, 1'b0, 33);

        // Division special cases resolve in one cycle
        run("divu_by0", C_OP, 3'd5, F7M, 32'd123, 32'd0, 32'd0, 32'd0, 5'd20, 32'hFFFFFFFF, 1'b0, 1);
        run("remu_by0", C_OP, 3'd7, F7M, 32'd55, 32'd0, 32'd0, 32'd0, 5'd21, 32'd55, 1'b0, 1);
        run("rem_ovf",  C_OP, 3'd6, F7M, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd22, 32'd0, 1'b0, 1);
        run("div_ovf",  C_OP, 3'd4, F7M, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd23, 32'h80000000, 1'b0, 1);

        // Backpressure: result held while out_ready is low
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 5'd5, 32'd6});
        drive(C_OP, 3'd0, F7A, 32'd10, 32'd4, 32'd0, 32'd0, 5'd5, waited);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_result", {32'd0, result_o}, 64'd6);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        exp_q.push_back({1'b0, 5'd24, 32'd101});
        drive(C_OPI, 3'd0, 7'd0, 32'd100, 32'd0, 32'd1, 32'd0, 5'd24, waited);
        check("bp_same_cycle_accept", 64'(waited), 64'd1);
        wait_out("bp_addi", 1, 0);
        @(posedge clk);
        #1;

        // Reset during a division, then a clean division afterwards
        drive(C_OP, 3'd4, F7M, 32'd100, 32'd7, 32'd0, 32'd0, 5'd25, waited);
        repeat (10) @(negedge clk);
        check("mid_state_busy", {62'd0, dbg_state}, 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_result", {32'd0, result_o}, 64'd0);
        check("mid_rst_state", {62'd0, dbg_state}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        run("div_after_rst", C_OP, 3'd4, F7M, 32'hFFFFFF9C, 32'd7, 32'd0, 32'd0, 5'd26, 32'hFFFFFFF2, 1'b0, 33);

        // ebreak traps; the following lui clears the trap
        run("ebreak", C_SYS, 3'd0, 7'd0, 32'd0, 32'd0, 32'd1, 32'd0, 5'd0, 32'd0, 1'b1, 1);
        run("lui",    C_LUI, 3'd0, 7'd0, 32'd0, 32'd0, 32'h12345000, 32'd0, 5'd27, 32'h12345000, 1'b0, 1);
        run("ecall",  C_SYS, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd28, 32'd0, 1'b0, 1);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("idle_at_end", {62'd0, dbg_state}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
